// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: comparator codes, branch FSM state, watchdog limit
package core_pkg;

   // Comparator operation selector, encoded like the RV32 branch funct3 field
   typedef enum logic [2:0] {
      FUNC_EQ  = 3'd0,
      FUNC_NE  = 3'd1,
      FUNC_LT  = 3'd4,
      FUNC_GE  = 3'd5,
      FUNC_LTU = 3'd6,
      FUNC_GEU = 3'd7
   } comparator_func_code;

   // Branch resolver FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMPARE  = 2'd1,
      ST_REDIRECT = 2'd2
   } branch_state_t;

   // Consecutive COMPARE cycles without a comparator response before giving up
   localparam int WATCHDOG_LIMIT = 4;

   // Return address offset for JAL/JALR link values
   localparam logic [31:0] LINK_OFFSET = 32'd4;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational branch/jump target and link address adder
module branch_target_calc
   import core_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        jalr,
   output logic [31:0] target,
   output logic [31:0] link
);

   logic [31:0] base;
   logic [31:0] raw_sum;

   // JALR adds to rs1 and clears bit 0; branches and JAL add to the PC; all sums wrap
   always_comb begin
      base    = jalr ? rs1 : pc;
      raw_sum = base + imm;
      target  = jalr ? {raw_sum[31:1], 1'b0} : raw_sum;
      link    = pc + LINK_OFFSET;
   end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch/jump resolution FSM with comparator and fetch redirect handshakes (option: BRANCH_MISALIGN_CHECK_EN)
module branch_resolver
   import core_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                br_valid_ip,
   output logic                br_ready_op,
   input  comparator_func_code br_func_ip,
   input  logic                br_jump_ip,
   input  logic                br_jalr_ip,
   input  logic [31:0]         br_pc_ip,
   input  logic [31:0]         br_imm_ip,
   input  logic [31:0]         br_rs1_ip,
   input  logic [31:0]         br_rs2_ip,
   output logic                comp_enable_op,
   output comparator_func_code comp_func_op,
   output logic [31:0]         comp_operand_a_op,
   output logic [31:0]         comp_operand_b_op,
   input  logic                comp_result_ip,
   input  logic                comp_valid_ip,
   output logic                redirect_valid_op,
   output logic [31:0]         redirect_pc_op,
   input  logic                redirect_ready_ip,
   output logic                flush_op,
   output logic                link_valid_op,
   output logic [31:0]         link_data_op,
   output logic                illegal_op,
   output logic                misalign_op
);

   branch_state_t       state;
   branch_state_t       state_next;
   logic [1:0]          watchdog;
   logic                redirect_first;

   comparator_func_code r_func;
   logic                r_jump;
   logic                r_jalr;
   logic [31:0]         r_pc;
   logic [31:0]         r_imm;
   logic [31:0]         r_rs1;
   logic [31:0]         r_rs2;

   logic [31:0]         target;
   logic [31:0]         link;
   logic                accept;
   logic                is_jump;
   logic                wd_expire;
   logic                misaligned;

   branch_target_calc u_target_calc (
      .pc     (r_pc),
      .imm    (r_imm),
      .rs1    (r_rs1),
      .jalr   (r_jalr),
      .target (target),
      .link   (link)
   );

   assign br_ready_op = (state == ST_IDLE) && reset;
   assign accept      = br_valid_ip && br_ready_op;
   assign is_jump     = r_jump || r_jalr;
   assign wd_expire   = (watchdog == 2'(WATCHDOG_LIMIT - 1));

`ifdef BRANCH_MISALIGN_CHECK_EN
   assign misaligned = target[1];
`else
   assign misaligned = 1'b0;
`endif

   // State register, watchdog and first-redirect-cycle marker
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= ST_IDLE;
         watchdog       <= 2'd0;
         redirect_first <= 1'b0;
      end else begin
         state          <= state_next;
         redirect_first <= (state != ST_REDIRECT) && (state_next == ST_REDIRECT);
         if ((state == ST_COMPARE) && !comp_valid_ip && !wd_expire) begin
            watchdog <= watchdog + 2'd1;
         end else begin
            watchdog <= 2'd0;
         end
      end
   end

   // Capture the request fields on the accepting handshake
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_func <= FUNC_EQ;
         r_jump <= 1'b0;
         r_jalr <= 1'b0;
         r_pc   <= 32'd0;
         r_imm  <= 32'd0;
         r_rs1  <= 32'd0;
         r_rs2  <= 32'd0;
      end else if (accept) begin
         r_func <= br_func_ip;
         r_jump <= br_jump_ip;
         r_jalr <= br_jalr_ip;
         r_pc   <= br_pc_ip;
         r_imm  <= br_imm_ip;
         r_rs1  <= br_rs1_ip;
         r_rs2  <= br_rs2_ip;
      end
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = (br_jump_ip || br_jalr_ip) ? ST_REDIRECT : ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (comp_valid_ip) begin
               state_next = comp_result_ip ? ST_REDIRECT : ST_IDLE;
            end else if (wd_expire) begin
               state_next = ST_IDLE;
            end
         end
         ST_REDIRECT: begin
            if (misaligned || redirect_ready_ip) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state; everything idles at zero
   always_comb begin
      comp_enable_op    = 1'b0;
      comp_func_op      = FUNC_EQ;
      comp_operand_a_op = 32'd0;
      comp_operand_b_op = 32'd0;
      redirect_valid_op = 1'b0;
      redirect_pc_op    = 32'd0;
      flush_op          = 1'b0;
      link_valid_op     = 1'b0;
      link_data_op      = 32'd0;
      illegal_op        = 1'b0;
      misalign_op       = 1'b0;
      case (state)
         ST_COMPARE: begin
            comp_enable_op    = 1'b1;
            comp_func_op      = r_func;
            comp_operand_a_op = r_rs1;
            comp_operand_b_op = r_rs2;
            illegal_op        = !comp_valid_ip && wd_expire;
         end
         ST_REDIRECT: begin
            if (misaligned) begin
               misalign_op = 1'b1;
            end else begin
               redirect_valid_op = 1'b1;
               redirect_pc_op    = target;
               flush_op          = redirect_first;
               if (redirect_ready_ip && is_jump) begin
                  link_valid_op = 1'b1;
                  link_data_op  = link;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have br_valid_ip in 1 and br_ready_op out 1: decode branch request handshake.
REQ-004 SHALL have br_func_ip in comparator_func_code, br_jump_ip in 1 (JAL), br_jalr_ip in 1 (JALR).
REQ-005 SHALL have br_pc_ip, br_imm_ip, br_rs1_ip, br_rs2_ip, all in 32: branch PC, sign-extended immediate, source operands.
REQ-006 SHALL have comp_enable_op out 1, comp_func_op out comparator_func_code, comp_operand_a_op and comp_operand_b_op out 32: comparator request.
REQ-007 SHALL have comp_result_ip in 1 and comp_valid_ip in 1: comparator response, same-cycle combinational.
REQ-008 SHALL have redirect_valid_op out 1, redirect_pc_op out 32, redirect_ready_ip in 1: fetch redirect handshake.
REQ-009 SHALL have flush_op out 1, link_valid_op out 1, link_data_op out 32, illegal_op out 1, misalign_op out 1.

Function
REQ-010 SHALL implement states IDLE, COMPARE, REDIRECT.
REQ-011 br_ready_op SHALL be 1 only in IDLE; request accepted when br_valid_ip && br_ready_op, registering all request fields.
REQ-012 Accepted conditional branch (both jump flags 0) SHALL go IDLE->COMPARE.
REQ-013 Accepted JAL or JALR SHALL go IDLE->REDIRECT, never asserting comp_enable_op; JALR wins if both flags are set.
REQ-014 In COMPARE, comp_enable_op SHALL be 1 with registered func/rs1/rs2; elsewhere comp_enable_op 0, comp operands 0.
REQ-015 In COMPARE with comp_valid_ip=1: result 1 -> REDIRECT; result 0 -> IDLE, no redirect.
REQ-016 In COMPARE with comp_valid_ip=0, a 2-bit watchdog SHALL count; after 4 consecutive cycles -> IDLE with illegal_op pulsed 1 cycle, no redirect.
REQ-017 Target SHALL be pc+imm for branch/JAL and (rs1+imm)&32'hFFFF_FFFE for JALR, modulo 2^32 (wrap, no overflow flag).
REQ-018 In REDIRECT, redirect_valid_op=1 and redirect_pc_op=target, both held stable until redirect_ready_ip=1; then -> IDLE.
REQ-019 flush_op SHALL pulse exactly on the first cycle of REDIRECT, regardless of redirect_ready_ip.
REQ-020 For jumps, link_valid_op SHALL pulse with link_data_op=pc+4 (wrapping) on the redirect handshake cycle; otherwise 0.
REQ-021 Back-to-back: request SHALL be acceptable the cycle after return to IDLE (min 2 cycles per taken branch, no comb ready path from redirect_ready_ip).
REQ-022 redirect_pc_op SHALL be 0 when redirect_valid_op=0.

Reset
REQ-023 reset=0 SHALL force IDLE, watchdog 0, all registered fields 0, within one clk edge, including mid-COMPARE or mid-REDIRECT (pending redirect dropped).
REQ-024 During and after reset: br_ready_op=1 only once reset=1; all other outputs 0.

Configuration
REQ-025 Macro BRANCH_MISALIGN_CHECK_EN defined: target[1]=1 SHALL, instead of REDIRECT, return to IDLE and pulse misalign_op 1 cycle; no flush, no link.
REQ-026 Macro undefined: misalign_op SHALL be tied 0 and target[1] ignored.

Structure
REQ-027 comparator_func_code SHALL be reused from CORE_PKG; a branch_state_t enum and WATCHDOG_LIMIT=4 SHALL be added to CORE_PKG.
REQ-028 One sub-module, branch_target_calc (combinational target and link adder), SHALL be instantiated; FSM stays in branch_resolver.

Verification
REQ-029 BEQ pc=0x100 imm=0x20 rs1=rs2=5, comparator result 1 -> flush pulse, redirect_pc_op=0x120, held until ready.
REQ-030 BLT rs1=7 rs2=3, result 0 -> back to IDLE after 1 COMPARE cycle, no redirect/flush, next request accepted immediately.
REQ-031 JALR rs1=0x1003 imm=0 -> no comp_enable, redirect_pc_op=0x1002, link_data_op=pc+4 pulsed at handshake; with macro, misalign_op=1 instead.
REQ-032 JAL pc=0xFFFF_FFFC imm=8 -> redirect_pc_op=0x4, link_data_op=0x0 (wrap).
REQ-033 comp_valid_ip held 0 in COMPARE -> illegal_op pulse after 4 cycles, IDLE, no redirect.
REQ-034 reset=0 during REDIRECT with redirect_ready_ip=0 -> next cycle redirect_valid_op=0, br_ready_op=1 after release.
